ex_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the decoded operands and funct3 of M-extension instructions latched by ID/EX. It runs a 32-step shift-add multiply or restoring divide, stalls the front end via `busy`, and presents a one-cycle `done` result to the EX/MEM stage. The block operates on posedge `clk`; ID/EX updates on negedge, so inputs are stable at every posedge.

---
 rtl/ex_muldiv_if.sv | 26 ++
 rtl/ex_muldiv.sv | 165 ++++++++++++++++
 tb/tb_ex_muldiv.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// Operand/result bundle between ID/EX, the RV32M multiply/divide unit and EX/MEM.
// master drives the instruction side; slave is the execution unit.
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [4:0]      rd_in;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, funct3, op1, op2, rd_in, flush,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, funct3, op1, op2, rd_in, flush,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply (32-step shift-add) / restoring divide for the EX stage.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier; division stays iterative.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input logic       clk,
  input logic       rst,
  ex_muldiv_if.slave bus
);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state_reg;
  logic [2:0]        f3_reg;
  logic [4:0]        rd_reg;
  logic              neg_reg;
  logic [XLEN-1:0]   opa_reg;
  logic [XLEN-1:0]   opb_reg;
  logic [2*XLEN-1:0] acc_reg;
  logic [4:0]        cnt_reg;
  logic              done_reg;
  logic [XLEN-1:0]   result_reg;
  logic [4:0]        rd_out_reg;

  logic              is_div;
  logic              sign_a;
  logic              sign_b;
  logic              neg_in;
  logic              div_zero;
  logic              div_ovf;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN-1:0]   special;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_shift;
  logic [XLEN+1:0]   trial;
  logic [2*XLEN-1:0] step_next;

  // Operand decode at acceptance; MULHSU treats only op1 as signed.
  always_comb begin
    is_div   = bus.funct3[2];
    sign_a   = bus.op1[XLEN-1] & (is_div ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11));
    sign_b   = bus.op2[XLEN-1] & (is_div ? ~bus.funct3[0] : ~bus.funct3[1]);
    neg_in   = (is_div && bus.funct3[1]) ? sign_a : (sign_a ^ sign_b);
    mag_a    = sign_a ? -bus.op1 : bus.op1;
    mag_b    = sign_b ? -bus.op2 : bus.op2;
    div_zero = is_div && (bus.op2 == '0);
    div_ovf  = is_div && !bus.funct3[0] && (bus.op1 == MIN_INT) && (bus.op2 == '1);
    if (div_zero)
      special = bus.funct3[1] ? bus.op1 : '1;
    else
      special = bus.funct3[1] ? '0 : MIN_INT;
  end

  // One iteration: multiply shifts acc right, divide shifts remainder:quotient left.
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (opb_reg[0] ? {1'b0, opa_reg} : '0);
    rem_shift = {acc_reg[2*XLEN-1:XLEN], opa_reg[XLEN-1]};
    trial     = {1'b0, rem_shift} - {2'b00, opb_reg};
    if (state_reg == MUL)
      step_next = {mul_sum, acc_reg[XLEN-1:1]};
    else if (trial[XLEN+1])
      step_next = {rem_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
    else
      step_next = {trial[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
  end

  function automatic logic [XLEN-1:0] fixup(input logic [2*XLEN-1:0] raw,
                                            input logic [2:0] f3,
                                            input logic neg);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   part;
    prod = neg ? -raw : raw;
    if (!f3[2]) begin
      part = (f3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end else begin
      part = f3[1] ? raw[2*XLEN-1:XLEN] : raw[XLEN-1:0];
      if (neg)
        part = -part;
    end
    return part;
  endfunction

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  always_comb fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      f3_reg     <= '0;
      rd_reg     <= '0;
      neg_reg    <= 1'b0;
      opa_reg    <= '0;
      opb_reg    <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      done_reg   <= 1'b0;
      result_reg <= '0;
      rd_out_reg <= '0;
    end else if (bus.flush) begin
      state_reg <= IDLE;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            f3_reg  <= bus.funct3;
            rd_reg  <= bus.rd_in;
            neg_reg <= neg_in;
            opa_reg <= mag_a;
            opb_reg <= mag_b;
            acc_reg <= '0;
            cnt_reg <= '0;
            if (div_zero || div_ovf) begin
              result_reg <= special;
              rd_out_reg <= bus.rd_in;
              done_reg   <= 1'b1;
              state_reg  <= DONE;
            end else if (is_div) begin
              state_reg <= DIV;
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              result_reg <= fixup(fast_prod, bus.funct3, neg_in);
              rd_out_reg <= bus.rd_in;
              done_reg   <= 1'b1;
              state_reg  <= DONE;
`else
              state_reg <= MUL;
`endif
            end
          end
        end
        MUL, DIV: begin
          acc_reg <= step_next;
          cnt_reg <= cnt_reg + 5'd1;
          if (state_reg == MUL)
            opb_reg <= opb_reg >> 1;
          else
            opa_reg <= opa_reg << 1;
          // Last step lands together with the sign fixup so done follows 32 edges after acceptance.
          if (cnt_reg == 5'd31) begin
            result_reg <= fixup(step_next, f3_reg, neg_reg);
            rd_out_reg <= rd_reg;
            done_reg   <= 1'b1;
            state_reg  <= DONE;
          end
        end
        default: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = !rst && ((state_reg == IDLE && bus.start) || state_reg == MUL || state_reg == DIV);
  assign bus.done   = done_reg;
  assign bus.result = result_reg;
  assign bus.rd_out = rd_out_reg;
endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: expected result/rd/done-cycle queued at issue, checked on done.
module tb_ex_muldiv;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MLAT = 0;
`else
  localparam int MLAT = 32;
`endif
  localparam int DLAT = 32;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          due;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ex_muldiv_if #(.XLEN(32)) bus ();
  ex_muldiv #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
    end
  endtask

  // Completion monitor: every done must match the oldest issued operation.
  always @(posedge clk) begin
    #1;
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'(bus.done), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        $display("op %-10s rd=%0d result=0x%08h cycle=%0d", mon_e.tag, bus.rd_out, bus.result, cyc);
        check({mon_e.tag, "_result"}, bus.result, mon_e.res);
        check({mon_e.tag, "_rd"}, {27'd0, bus.rd_out}, {27'd0, mon_e.rd});
        check({mon_e.tag, "_latency"}, 32'(cyc), 32'(mon_e.due));
      end
    end
  end

  // hold=1 drives start during the DONE cycle, which the unit must ignore for one edge.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] want,
                        input int lat, input bit hold);
    exp_t e;
    int   n;
    int   edges;
    edges = hold ? 2 : 1;
    if (!hold) @(posedge clk);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.op1    = a;
    bus.op2    = b;
    bus.rd_in  = rd;
    e.res = want;
    e.rd  = rd;
    e.due = cyc + edges + lat;
    e.tag = tag;
    sb.push_back(e);
    repeat (edges) @(posedge clk);
    #1;
    bus.start = 1'b0;
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      @(posedge clk);
      #1;
      n++;
    end
    if (bus.done !== 1'b1)
      check({tag, "_timeout"}, 32'(bus.done), 32'd1);
    else
      check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    rst        = 1'b1;
    bus.start  = 1'b1;
    bus.funct3 = 3'd0;
    bus.op1    = '0;
    bus.op2    = '0;
    bus.rd_in  = '0;
    bus.flush  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_rd", {27'd0, bus.rd_out}, 32'd0);
    check("rst_busy_forced", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    rst       = 1'b0;

    run_op("mul", 3'b000, 32'd7, 32'hFFFFFFFD, 5'd3, 32'hFFFFFFEB, MLAT, 1'b0);
    run_op("mul_lo", 3'b000, 32'h12345678, 32'h10, 5'd4, 32'h23456780, MLAT, 1'b0);
    run_op("mulh", 3'b001, 32'h80000000, 32'hFFFFFFFF, 5'd5, 32'h00000000, MLAT, 1'b0);
    run_op("mulhu", 3'b011, 32'h80000000, 32'hFFFFFFFF, 5'd6, 32'h7FFFFFFF, MLAT, 1'b0);
    run_op("mulhsu", 3'b010, 32'h80000000, 32'hFFFFFFFF, 5'd7, 32'h80000000, MLAT, 1'b0);
    run_op("mulhu_max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 32'hFFFFFFFE, MLAT, 1'b0);
    run_op("div", 3'b100, 32'hFFFFFFF9, 32'd2, 5'd9, 32'hFFFFFFFD, DLAT, 1'b0);
    run_op("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 5'd10, 32'hFFFFFFFF, DLAT, 1'b0);
    run_op("div_negb", 3'b100, 32'd7, 32'hFFFFFFFE, 5'd11, 32'hFFFFFFFD, DLAT, 1'b0);
    run_op("rem_negb", 3'b110, 32'd7, 32'hFFFFFFFE, 5'd12, 32'd1, DLAT, 1'b0);
    run_op("divu", 3'b101, 32'd100, 32'd7, 5'd13, 32'd14, DLAT, 1'b0);
    run_op("remu", 3'b111, 32'd100, 32'd7, 5'd14, 32'd2, DLAT, 1'b0);
    run_op("divu_max", 3'b101, 32'hFFFFFFFF, 32'd1, 5'd15, 32'hFFFFFFFF, DLAT, 1'b0);
    run_op("div_by0", 3'b100, 32'd1234, 32'd0, 5'd16, 32'hFFFFFFFF, 0, 1'b0);
    run_op("rem_by0", 3'b110, 32'd1234, 32'd0, 5'd17, 32'd1234, 0, 1'b0);
    run_op("remu_by0", 3'b111, 32'h80000000, 32'd0, 5'd18, 32'h80000000, 0, 1'b0);
    run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h80000000, 0, 1'b0);
    run_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd20, 32'd0, 0, 1'b0);

    // Flush mid-divide: no completion, unit idle afterwards.
    @(posedge clk);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'b100;
    bus.op1    = 32'd1000;
    bus.op2    = 32'd3;
    bus.rd_in  = 5'd21;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 35; i++) begin
      check("flush_no_done", 32'(bus.done), 32'd0);
      @(posedge clk);
      #1;
    end
    run_op("after_flush", 3'b101, 32'd1000, 32'd3, 5'd22, 32'd333, DLAT, 1'b0);

    // Reset in the middle of an iterative operation clears every output.
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
    bus.funct3 = 3'b101;
`else
    bus.funct3 = 3'b000;
`endif
    bus.op1   = 32'd3;
    bus.op2   = 32'd5;
    bus.rd_in = 5'd23;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_result", bus.result, 32'd0);
    check("midrst_rd", {27'd0, bus.rd_out}, 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;

    // Back-to-back DIVU with start held through DONE: 34 cycles between completions.
    run_op("b2b_first", 3'b101, 32'd50000, 32'd7, 5'd24, 32'd7142, DLAT, 1'b0);
    run_op("b2b_second", 3'b101, 32'd77, 32'd11, 5'd25, 32'd7, DLAT, 1'b1);

    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = $urandom_range(1, 32'h0001FFFF);
      run_op("rnd_divu", 3'b101, a, b, 5'(i + 1), a / b, DLAT, 1'b0);
      run_op("rnd_remu", 3'b111, a, b, 5'(i + 5), a % b, DLAT, 1'b0);
      b = $urandom;
      run_op("rnd_mulhu", 3'b011, a, b, 5'(i + 9), 32'((64'(a) * 64'(b)) >> 32), MLAT, 1'b0);
      run_op("rnd_mul", 3'b000, a, b, 5'(i + 13), a * b, MLAT, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
